fetch_stage: RTL

- Instruction fetch stage and IF/ID pipeline register, directly upstream of the control unit.
- Drives the synchronous instruction memory and sequences the program counter.
- Absorbs decode stalls with a one-entry hold buffer.
- Applies taken-branch/jump redirects from execute, and presents the 4-bit opcode and the full instruction to decode.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_stage.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, default widths and fetch FSM states.
package cpu_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int ADDR_W_DEF  = 8;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1111;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, one-entry stall hold buffer
// and execute-stage redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [3:0]         opcode
);

  fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
  logic               hold_valid_q, hold_valid_d;
  logic               ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_d;

  logic run_go, run_stall, hold_go;

  assign run_go    = !redirect_valid && !stall && (state_q == RUN);
  assign run_stall = !redirect_valid && stall && (state_q == RUN);
  assign hold_go   = !redirect_valid && !stall && (state_q == HOLD);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    hold_d        = hold_q;
    hold_pc_d     = hold_pc_q;
    hold_valid_d  = hold_valid_q;
    ifid_valid_d  = ifid_valid;
    ifid_instr_d  = ifid_instr;
    ifid_pc_d     = ifid_pc;
    imem_en       = 1'b0;
    imem_addr     = pc_q;
    unique case (1'b1)
      redirect_valid: begin
        // Squash IF/ID and any buffered or returning data.
        ifid_valid_d  = 1'b0;
        ifid_instr_d  = '0;
        hold_valid_d  = 1'b0;
        imem_en       = 1'b1;
        imem_addr     = redirect_target;
        pc_d          = redirect_target + ADDR_W'(1);
        inflight_d    = 1'b1;
        inflight_pc_d = redirect_target;
        state_d       = RUN;
      end
      run_go: begin
        imem_en       = 1'b1;
        pc_d          = pc_q + ADDR_W'(1);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        ifid_valid_d  = inflight_q;
        if (inflight_q) begin
          ifid_instr_d = imem_rdata;
          ifid_pc_d    = inflight_pc_q;
        end
      end
      run_stall: begin
        inflight_d = 1'b0;
        if (inflight_q) begin
          hold_d       = imem_rdata;
          hold_pc_d    = inflight_pc_q;
          hold_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      hold_go: begin
        ifid_valid_d  = 1'b1;
        ifid_instr_d  = hold_q;
        ifid_pc_d     = hold_pc_q;
        hold_valid_d  = 1'b0;
        imem_en       = 1'b1;
        pc_d          = pc_q + ADDR_W'(1);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        state_d       = RUN;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      hold_q        <= '0;
      hold_pc_q     <= '0;
      hold_valid_q  <= 1'b0;
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      hold_q        <= hold_d;
      hold_pc_q     <= hold_pc_d;
      hold_valid_q  <= hold_valid_d;
      ifid_valid    <= ifid_valid_d;
      ifid_instr    <= ifid_instr_d;
      ifid_pc       <= ifid_pc_d;
    end
  end

  assign opcode = ifid_valid ? ifid_instr[INSTR_W-1 -: 4] : OP_NOP;

endmodule
